// File: rtl/processador.sv
// processador: 16-bit four-step multi-cycle core with one shared, observable bus.
// Optional macro PROC_SIGNED_IMM_EN makes mvi sign-extend its 10-bit immediate from bit 9.
module processador (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] iin,
  output logic [15:0] bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_MVI = 3'b101,
    OP_SRL = 3'b110,
    OP_MV  = 3'b111
  } opcode_t;

  step_t       step_q;
  step_t       step_d;
  logic [15:0] instr_q;
  logic [15:0] regFile_q [8];
  logic [15:0] accum_q;
  logic [15:0] result_q;
  logic [15:0] result_d;
  logic [15:0] busVal;
  logic [15:0] immExt;
  opcode_t     opcode;
  logic [2:0]  xSel;
  logic [2:0]  ySel;
  logic        isMove;

  assign opcode = opcode_t'(instr_q[15:13]);
  assign xSel   = instr_q[12:10];
  assign ySel   = instr_q[9:7];
  assign isMove = (opcode == OP_MV) || (opcode == OP_MVI);

`ifdef PROC_SIGNED_IMM_EN
  assign immExt = {{6{instr_q[9]}}, instr_q[9:0]};
`else
  assign immExt = {6'b000000, instr_q[9:0]};
`endif

  // Exactly one source drives the bus per step; idle steps of moves and reset drive zero.
  always_comb begin
    busVal = 16'h0000;
    if (!resetn) begin
      case (step_q)
        T0: busVal = iin;
        T1: begin
          if (opcode == OP_MV)       busVal = regFile_q[ySel];
          else if (opcode == OP_MVI) busVal = immExt;
          else                       busVal = regFile_q[xSel];
        end
        T2: if (!isMove) busVal = regFile_q[ySel];
        T3: if (!isMove) busVal = result_q;
        default: busVal = 16'h0000;
      endcase
    end
  end

  assign bus = busVal;

  // The second ALU operand is whatever the bus carries in T2 (Ry).
  always_comb begin
    result_d = 16'h0000;
    case (opcode)
      OP_ADD:  result_d = accum_q + busVal;
      OP_SUB:  result_d = accum_q - busVal;
      OP_OR:   result_d = accum_q | busVal;
      OP_SLT:  result_d = {15'h0000, ($signed(accum_q) < $signed(busVal))};
      OP_SLL:  result_d = accum_q << busVal[3:0];
      OP_SRL:  result_d = accum_q >> busVal[3:0];
      default: result_d = 16'h0000;
    endcase
  end

  always_comb begin
    step_d = T0;
    case (step_q)
      T0:      step_d = T1;
      T1:      step_d = T2;
      T2:      step_d = T3;
      default: step_d = T0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      step_q   <= T0;
      instr_q  <= 16'h0000;
      accum_q  <= 16'h0000;
      result_q <= 16'h0000;
      for (int i = 0; i < 8; i++) begin
        regFile_q[i] <= 16'h0000;
      end
    end else begin
      step_q <= step_d;
      case (step_q)
        T0: instr_q <= iin;
        T1: begin
          if (isMove) regFile_q[xSel] <= busVal;
          else        accum_q         <= busVal;
        end
        T2: if (!isMove) result_q <= result_d;
        T3: if (!isMove) regFile_q[xSel] <= busVal;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processador.sv
// tb_processador: drives one instruction per 4-clock window and checks the bus every step
// against a reference register model through a scoreboard queue.
module tb_processador;

  logic        clock;
  logic        resetn;
  logic [15:0] iin;
  logic [15:0] bus;

  logic [15:0] expQ [$];
  logic [15:0] model [8];
  int compareCount = 0;
  int failCount    = 0;

  processador dut (
    .clock  (clock),
    .resetn (resetn),
    .iin    (iin),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] immOf(input logic [15:0] instr);
`ifdef PROC_SIGNED_IMM_EN
    return {{6{instr[9]}}, instr[9:0]};
`else
    return {6'b000000, instr[9:0]};
`endif
  endfunction

  function automatic logic [15:0] aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a | b;
      3'b011:  return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      3'b100:  return a << b[3:0];
      3'b110:  return a >> b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  // Pushes the four bus values the instruction must produce and updates the model.
  task automatic pushExpected(input logic [15:0] instr);
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic [15:0] r;
    op = instr[15:13];
    x  = instr[12:10];
    y  = instr[9:7];
    expQ.push_back(instr);
    if (op == 3'b111) begin
      expQ.push_back(model[y]);
      expQ.push_back(16'h0000);
      expQ.push_back(16'h0000);
      model[x] = model[y];
    end else if (op == 3'b101) begin
      expQ.push_back(immOf(instr));
      expQ.push_back(16'h0000);
      expQ.push_back(16'h0000);
      model[x] = immOf(instr);
    end else begin
      r = aluRef(op, model[x], model[y]);
      expQ.push_back(model[x]);
      expQ.push_back(model[y]);
      expQ.push_back(r);
      model[x] = r;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] expVal;
    compareCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s: scoreboard empty, observed %h", tag, bus);
    end else begin
      expVal = expQ.pop_front();
      assert (bus === expVal) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, bus, expVal);
      end
    end
  endtask

  // Called just after a rising edge with the sequencer about to sit in T0.
  task automatic applyStimulus(input logic [15:0] instr, input string name);
    #1 iin = instr;
    pushExpected(instr);
    for (int s = 0; s < 4; s++) begin
      #1;
      checkOutput($sformatf("%s T%0d", name, s));
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b1;
    iin    = 16'h0000;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    repeat (3) @(posedge clock);
    #1;
    expQ.push_back(16'h0000);
    checkOutput("reset bus");
    resetn = 1'b0;

    applyStimulus(16'hA01C, "mvi R0,28");
    applyStimulus(16'hA40A, "mvi R1,10");
    applyStimulus(16'h2080, "sub R0,R1");
    applyStimulus(16'hE800, "mv R2,R0");
    applyStimulus(16'hED00, "mv R3,R2");
    applyStimulus(16'h0D80, "add R3,R3");
    applyStimulus(16'h2900, "sub R2,R2");
    applyStimulus(16'h4500, "or R1,R2");
    applyStimulus(16'h8000, "sll R0,R0");
    applyStimulus(16'hE400, "mv R1,R0");
    applyStimulus(16'hB401, "mvi R5,1");
    applyStimulus(16'h3280, "sub R4,R5");
    applyStimulus(16'hFA00, "mv R6,R4");
    applyStimulus(16'h7280, "slt R4,R5");
    applyStimulus(16'h1A80, "add R6,R5");
    applyStimulus(16'hE800, "mv R2,R0");
    applyStimulus(16'hBE00, "mvi R7,0x200");
    applyStimulus(16'hDE80, "srl R7,R5");
    applyStimulus(16'hF780, "mv R5,R7");
    applyStimulus(16'hB805, "mvi R6,5");

    // add R6,R6 abandoned by a reset asserted during its T2.
    #1 iin = 16'h1B00;
    expQ.push_back(16'h1B00);
    #1 checkOutput("abort add T0");
    @(posedge clock);
    #1;
    expQ.push_back(16'h0005);
    checkOutput("abort add T1");
    @(posedge clock);
    #1 resetn = 1'b1;
    expQ.push_back(16'h0000);
    #1 checkOutput("bus during reset");
    @(posedge clock);
    #1;
    expQ.push_back(16'h0000);
    checkOutput("bus after reset edge");
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    applyStimulus(16'hFF00, "mv R7,R6 post-reset");
    applyStimulus(16'h1B00, "add R6,R6 post-reset");

    if (expQ.size() != 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
